// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between an instruction fetch
//   port and a data port. At most one access is in flight. The data port wins
//   ties unless the fetch port has been denied STARVE_MAX times in a row.
//
// Parameters
//   LAT        : memory read latency in cycles (1..15)
//   STARVE_MAX : consecutive fetch denials before fetch is forced to win (1..15)
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   if_req/if_addr/if_kill     : fetch request, byte address, redirect (drops fetch)
//   if_gnt/if_rvalid/if_rdata  : fetch grant, response valid, response data
//   stallF                     : fetch stage stall (request pending, no data yet)
//   dm_req/dm_we/dm_addr/dm_wdata : data request, write enable, address, write data
//   dm_gnt/dm_rvalid/dm_rdata  : data grant, read data / write ack valid, read data
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe, write strobe, address, data
//   mem_rdata                  : memory read data, valid LAT cycles after mem_en

module mem_port_arbiter #(
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        stallF,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  localparam logic [3:0] LatLoad     = 4'(LAT - 1);
  localparam logic [3:0] StarveLimit = 4'(STARVE_MAX);

  state_e     stateQ, stateD;
  logic [3:0] cntQ, cntD;
  logic [3:0] starveQ, starveD;
  logic       ownerFetchQ, ownerFetchD;
  logic       weQ, weD;
  logic       killedQ, killedD;
  logic       fetchWins;
  logic       respCycle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ      <= StIdle;
      cntQ        <= 4'd0;
      starveQ     <= 4'd0;
      ownerFetchQ <= 1'b0;
      weQ         <= 1'b0;
      killedQ     <= 1'b0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      starveQ     <= starveD;
      ownerFetchQ <= ownerFetchD;
      weQ         <= weD;
      killedQ     <= killedD;
    end
  end

  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    starveD     = starveQ;
    ownerFetchD = ownerFetchQ;
    weD         = weQ;
    killedD     = killedQ;
    fetchWins   = 1'b0;
    respCycle   = 1'b0;

    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    stallF    = 1'b0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = 32'd0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;

    // Outputs are held at zero for as long as reset is asserted, including the
    // purely combinational ones that would otherwise follow the request inputs.
    if (!reset) begin
      unique case (stateQ)
        StIdle: begin
          // Data wins ties, except when fetch has been starved long enough.
          fetchWins = if_req && (!dm_req || (starveQ == StarveLimit));
          if (fetchWins) begin
            if_gnt      = 1'b1;
            mem_en      = 1'b1;
            mem_addr    = if_addr;
            stateD      = StBusy;
            cntD        = LatLoad;
            ownerFetchD = 1'b1;
            weD         = 1'b0;
            // A redirect in the grant cycle already orphans this fetch.
            killedD     = if_kill;
          end else if (dm_req) begin
            dm_gnt      = 1'b1;
            mem_en      = 1'b1;
            mem_we      = dm_we;
            mem_addr    = dm_addr;
            mem_wdata   = dm_wdata;
            stateD      = StBusy;
            cntD        = LatLoad;
            ownerFetchD = 1'b0;
            weD         = dm_we;
            killedD     = 1'b0;
          end
        end

        StBusy: begin
          if (ownerFetchQ && if_kill) begin
            killedD = 1'b1;
          end
          if (cntQ == 4'd0) begin
            // Response cycle: the memory data is on mem_rdata now.
            respCycle = 1'b1;
            stateD    = StIdle;
            killedD   = 1'b0;
          end else begin
            cntD = cntQ - 4'd1;
          end
        end
      endcase

      if (respCycle) begin
        if (ownerFetchQ) begin
          // A late redirect in the response cycle itself also drops the data.
          if_rvalid = !killedQ && !if_kill;
          if_rdata  = if_rvalid ? mem_rdata : 32'd0;
        end else begin
          dm_rvalid = 1'b1;
          // Writes are acknowledged with zero data.
          dm_rdata  = weQ ? 32'd0 : mem_rdata;
        end
      end

      if (!if_req || if_gnt) begin
        starveD = 4'd0;
      end else if (dm_gnt && (starveQ != StarveLimit)) begin
        starveD = starveQ + 4'd1;
      end

      stallF = if_req && !if_rvalid;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int Lat       = 2;
  localparam int StarveMax = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_kill = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, stallF;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter #(
    .LAT       (Lat),
    .STARVE_MAX(StarveMax)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_kill  (if_kill),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .stallF   (stallF),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  // ---------------- reference model (cycle-indexed, transaction level) ------
  int mCyc, mDue, mStarve;
  bit mFetch, mWrite, mKilled;
  logic eIfGnt, eIfRv, eStall, eDmGnt, eDmRv, eMemEn, eMemWe;
  logic [31:0] eIfRd, eDmRd, eMemAddr, eMemWd;

  function automatic logic [134:0] outVec();
    return {if_gnt, if_rvalid, if_rdata, stallF, dm_gnt, dm_rvalid, dm_rdata,
            mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic logic [134:0] expVec();
    return {eIfGnt, eIfRv, eIfRd, eStall, eDmGnt, eDmRv, eDmRd,
            eMemEn, eMemWe, eMemAddr, eMemWd};
  endfunction

  function void mdlReset();
    mCyc = 0; mDue = -1; mStarve = 0; mFetch = 0; mWrite = 0; mKilled = 0;
  endfunction

  function void mdlEval();
    bit free, resp, fw;
    free = (mDue < mCyc);
    resp = (mDue == mCyc);
    fw   = free && if_req && (!dm_req || mStarve >= StarveMax);
    eIfGnt   = fw;
    eDmGnt   = free && dm_req && !fw;
    eIfRv    = resp && mFetch && !mKilled && !if_kill;
    eIfRd    = eIfRv ? mem_rdata : 32'd0;
    eDmRv    = resp && !mFetch;
    eDmRd    = (eDmRv && !mWrite) ? mem_rdata : 32'd0;
    eMemEn   = eIfGnt || eDmGnt;
    eMemWe   = eDmGnt && dm_we;
    eMemAddr = eIfGnt ? if_addr : (eDmGnt ? dm_addr : 32'd0);
    eMemWd   = eDmGnt ? dm_wdata : 32'd0;
    eStall   = if_req && !eIfRv;
  endfunction

  function void mdlStep();
    if (if_kill && mFetch && mDue >= mCyc) mKilled = 1;
    if (eIfGnt || eDmGnt) begin
      mDue    = mCyc + Lat;
      mFetch  = eIfGnt;
      mWrite  = eDmGnt && dm_we;
      mKilled = eIfGnt && if_kill;
    end
    if (!if_req || eIfGnt) mStarve = 0;
    else if (eDmGnt && mStarve < StarveMax) mStarve++;
    mCyc++;
  endfunction

  // ---------------- stimulus utilities -------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    if_req = 0; if_kill = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mdlReset();
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    reset = 1;
    if_req = 1; dm_req = 1; dm_we = 1; if_addr = 32'h44; dm_addr = 32'h88;
    dm_wdata = 32'h1234_5678; mem_rdata = 32'hFFFF_FFFF;
    #2;
    vecs++;
    if (outVec() !== '0) begin
      errs++; $display("FAIL reset_outputs: got %h want 0", outVec());
    end
    tick();
    reset = 0;
    #2;
    // First cycle out of reset: data wins the tie.
    vecs++;
    if ({if_gnt, dm_gnt, mem_en, mem_we, mem_addr} !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h88}) begin
      errs++;
      $display("FAIL reset_first_grant: got if_gnt=%b dm_gnt=%b en=%b we=%b addr=%h",
               if_gnt, dm_gnt, mem_en, mem_we, mem_addr);
    end
  endtask

  task automatic test_fetch_basic();
    doReset();
    if_req = 1; if_addr = 32'h40;
    #2;
    vecs++;
    if ({if_gnt, dm_gnt, mem_en, mem_we, mem_addr, mem_wdata, stallF} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1}) begin
      errs++;
      $display("FAIL fetch_c0: gnt=%b en=%b we=%b addr=%h stallF=%b want gnt=1 addr=40 stallF=1",
               if_gnt, mem_en, mem_we, mem_addr, stallF);
    end
    tick();
    mem_rdata = 32'h1111_2222;
    #2;
    vecs++;
    if ({if_gnt, if_rvalid, if_rdata, mem_en, stallF} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL fetch_c1: gnt=%b rvalid=%b rdata=%h en=%b stallF=%b", if_gnt, if_rvalid,
               if_rdata, mem_en, stallF);
    end
    tick();
    mem_rdata = 32'hCAFE_1234;
    #2;
    vecs++;
    if ({if_gnt, if_rvalid, if_rdata, mem_en, stallF} !==
        {1'b0, 1'b1, 32'hCAFE_1234, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL fetch_c2: gnt=%b rvalid=%b rdata=%h stallF=%b want rvalid=1 rdata=cafe1234",
               if_gnt, if_rvalid, if_rdata, stallF);
    end
    tick();
    if_req = 0;
    #2;
    vecs++;
    if ({if_rvalid, if_rdata, stallF} !== {1'b0, 32'h0, 1'b0}) begin
      errs++;
      $display("FAIL fetch_c3: rvalid=%b rdata=%h stallF=%b want 0", if_rvalid, if_rdata, stallF);
    end
  endtask

  task automatic test_starvation();
    int wins[$];
    doReset();
    if_req = 1; dm_req = 1; if_addr = 32'h100; dm_addr = 32'h200;
    for (int c = 0; c < 80 && wins.size() < 8; c++) begin
      #2;
      if (if_gnt) wins.push_back(1);
      else if (dm_gnt) wins.push_back(0);
      tick();
    end
    vecs++;
    if (wins.size() != 8) begin
      errs++; $display("FAIL starve_count: got %0d grants want 8", wins.size());
    end
    // Fetch wins every (StarveMax+1)-th opportunity, proving the counter restarts at 0.
    for (int i = 0; i < wins.size(); i++) begin
      vecs++;
      if (wins[i] != ((i % (StarveMax + 1)) == StarveMax)) begin
        errs++; $display("FAIL starve_order[%0d]: got fetch=%0d want fetch=%0d", i, wins[i],
                         (i % (StarveMax + 1)) == StarveMax);
      end
    end
    if_req = 0; dm_req = 0;
  endtask

  task automatic test_write();
    doReset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    #2;
    vecs++;
    if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
      errs++;
      $display("FAIL write_grant: gnt=%b en=%b we=%b addr=%h wdata=%h", dm_gnt, mem_en, mem_we,
               mem_addr, mem_wdata);
    end
    tick();
    dm_req = 0; dm_we = 0; dm_wdata = 0;
    #2;
    vecs++;
    if ({dm_rvalid, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errs++; $display("FAIL write_c1: rvalid=%b en=%b we=%b addr=%h wdata=%h want all 0",
                       dm_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    mem_rdata = 32'h5A5A_A5A5;
    #2;
    vecs++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0}) begin
      errs++; $display("FAIL write_ack: rvalid=%b rdata=%h want 1/0", dm_rvalid, dm_rdata);
    end
  endtask

  task automatic test_kill();
    doReset();
    if_req = 1; if_addr = 32'h80;
    #2;
    vecs++;
    if (if_gnt !== 1'b1) begin
      errs++; $display("FAIL kill_grant: if_gnt=%b want 1", if_gnt);
    end
    tick();
    if_req = 0; if_kill = 1; dm_req = 1; dm_addr = 32'h300;
    #2;
    vecs++;
    if (dm_gnt !== 1'b0) begin
      errs++; $display("FAIL kill_c1_dm_gnt: dm_gnt=%b want 0", dm_gnt);
    end
    tick();
    if_kill = 0; mem_rdata = 32'h7777_0000;
    #2;
    vecs++;
    if ({if_rvalid, if_rdata, dm_gnt} !== {1'b0, 32'h0, 1'b0}) begin
      errs++; $display("FAIL kill_c2: if_rvalid=%b if_rdata=%h dm_gnt=%b want 0", if_rvalid,
                       if_rdata, dm_gnt);
    end
    tick();
    #2;
    vecs++;
    if (dm_gnt !== 1'b1) begin
      errs++; $display("FAIL kill_c3_dm_gnt: dm_gnt=%b want 1", dm_gnt);
    end
    dm_req = 0;

    // Redirect landing in the response cycle itself.
    doReset();
    if_req = 1; if_addr = 32'h84;
    tick();
    if_req = 0;
    tick();
    if_kill = 1; mem_rdata = 32'h9999_9999;
    #2;
    vecs++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) begin
      errs++; $display("FAIL kill_resp_cycle: if_rvalid=%b if_rdata=%h want 0", if_rvalid,
                       if_rdata);
    end
    if_kill = 0;

    // Redirect while idle does not affect a later fetch.
    doReset();
    if_kill = 1;
    tick();
    if_kill = 0; if_req = 1; if_addr = 32'h88;
    tick();
    if_req = 0;
    tick();
    mem_rdata = 32'h0BAD_F00D;
    #2;
    vecs++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      errs++; $display("FAIL kill_idle_ignored: if_rvalid=%b if_rdata=%h want 1/0badf00d",
                       if_rvalid, if_rdata);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    #2;
    vecs++;
    if (dm_gnt !== 1'b1) begin
      errs++; $display("FAIL rstmid_grant: dm_gnt=%b want 1", dm_gnt);
    end
    tick();
    dm_req = 0; if_req = 1; if_addr = 32'h60; mem_rdata = 32'hABCD_EF01;
    reset = 1;
    #1;
    vecs++;
    if (outVec() !== '0) begin
      errs++; $display("FAIL rstmid_outputs: got %h want 0", outVec());
    end
    tick();
    reset = 0; if_req = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      vecs++;
      if ({dm_rvalid, dm_rdata} !== {1'b0, 32'h0}) begin
        errs++; $display("FAIL rstmid_no_rvalid[%0d]: dm_rvalid=%b dm_rdata=%h", c, dm_rvalid,
                         dm_rdata);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int gnts[$];
    logic prevEn;
    doReset();
    prevEn = 1'b0;
    dm_req = 1; dm_we = 0;
    for (int c = 0; c < 20; c++) begin
      dm_addr = 32'h1000 + 32'(c * 4);
      mem_rdata = $urandom;
      #2;
      vecs++;
      if (prevEn && mem_en) begin
        errs++; $display("FAIL b2b_mem_en_consecutive: cycle %0d mem_en=1 after mem_en=1", c);
      end
      prevEn = mem_en;
      if (dm_gnt) gnts.push_back(c);
      tick();
    end
    dm_req = 0;
    vecs++;
    if (gnts.size() < 6) begin
      errs++; $display("FAIL b2b_grant_count: got %0d want at least 6", gnts.size());
    end
    // Grant, LAT-1 busy cycles, response cycle (still busy), then next grant.
    for (int i = 1; i < gnts.size(); i++) begin
      vecs++;
      if (gnts[i] - gnts[i-1] != Lat + 1) begin
        errs++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, gnts[i] - gnts[i-1],
                         Lat + 1);
      end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 1500; c++) begin
      if_req    = ($urandom_range(0, 99) < 60);
      dm_req    = ($urandom_range(0, 99) < 55);
      dm_we     = $urandom_range(0, 1) == 1;
      if_kill   = ($urandom_range(0, 99) < 12);
      if_addr   = $urandom;
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      mem_rdata = $urandom;
      mdlEval();
      #2;
      vecs++;
      if (outVec() !== expVec()) begin
        errs++;
        $display("FAIL random[%0d]: got %h want %h", c, outVec(), expVec());
      end
      mdlStep();
      tick();
    end
    if_req = 0; dm_req = 0; if_kill = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_fetch_basic();
    test_starvation();
    test_write();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
